mult32_seq: RTL and testbench



---
 rtl/mult32_seq_pkg.sv | 30 +++
 rtl/mult32_seq_step.sv | 37 +++
 rtl/mult32_seq.sv | 150 +++++++++++++++
 tb/tb_mult32_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: widths, iteration
// count, FSM state encoding and two's-complement helpers.
package mult32_seq_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MULT_ITER  = 32;
    localparam int CNT_W      = 5;

    // Iteration counter value on the final add/shift step
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MULT_ITER - 1);

    typedef enum logic [2:0] {
        MULT_ST_IDLE = 3'd0,
        MULT_ST_LOAD = 3'd1,
        MULT_ST_ITER = 3'd2,
        MULT_ST_FIX  = 3'd3,
        MULT_ST_DONE = 3'd4
    } mult_state_e;

    // Two's-complement negate of a 32-bit word (magnitude of 0x80000000 is itself)
    function automatic logic [DATA_WIDTH-1:0] twoscomp32(input logic [DATA_WIDTH-1:0] v);
        return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negate of a 64-bit product
    function automatic logic [2*DATA_WIDTH-1:0] twoscomp64(input logic [2*DATA_WIDTH-1:0] v);
        return ~v + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mult32_seq_step.sv
// One add/shift step of the multiplier: conditionally add the multiplicand
// into the upper accumulator with a 32-bit ripple adder, then shift the
// 65-bit {carry, sum, mplier} right by one.
module mult32_seq_step
    import mult32_seq_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] acc_hi_i,
    input  logic [DATA_WIDTH-1:0] mplier_i,
    input  logic [DATA_WIDTH-1:0] mcand_i,
    output logic [DATA_WIDTH-1:0] acc_hi_o,
    output logic [DATA_WIDTH-1:0] mplier_o
);

    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum_bits;
    logic                  carry_out;

    // Partial product is the multiplicand only when the current multiplier LSB is set
    assign addend = mplier_i[0] ? mcand_i : '0;

    // Bit-serial ripple-carry adder; the carry out becomes bit 32 of the sum
    always_comb begin
        logic c;
        c        = 1'b0;
        sum_bits = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            sum_bits[i] = acc_hi_i[i] ^ addend[i] ^ c;
            c           = (acc_hi_i[i] & addend[i]) | (c & (acc_hi_i[i] ^ addend[i]));
        end
        carry_out = c;
    end

    // Right shift of {carry, sum, mplier}: sum LSB moves into the multiplier MSB
    assign acc_hi_o = {carry_out, sum_bits[DATA_WIDTH-1:1]};
    assign mplier_o = {sum_bits[0], mplier_i[DATA_WIDTH-1:1]};

endmodule

// File: rtl/mult32_seq.sv
// Multi-cycle 32x32 signed/unsigned multiplier with START/BUSY/DONE handshake.
// Operands are captured in IDLE, converted to magnitudes in LOAD, multiplied
// over 32 add/shift iterations, sign-corrected in FIX and presented on HI/LO.
module mult32_seq
    import mult32_seq_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    mult_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  signed_q, signed_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic [DATA_WIDTH-1:0]   step_acc_hi;
    logic [DATA_WIDTH-1:0]   step_mplier;
    logic [2*DATA_WIDTH-1:0] product;

    mult32_seq_step u_step (
        .acc_hi_i (acc_hi_q),
        .mplier_i (mplier_q),
        .mcand_i  (mcand_q),
        .acc_hi_o (step_acc_hi),
        .mplier_o (step_mplier)
    );

    // State register; reset drops straight back to IDLE at any time
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= MULT_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed-length sequence, START only honoured in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MULT_ST_IDLE: if (START) state_d = MULT_ST_LOAD;
            MULT_ST_LOAD: state_d = MULT_ST_ITER;
            MULT_ST_ITER: if (count_q == LAST_COUNT) state_d = MULT_ST_FIX;
            MULT_ST_FIX:  state_d = MULT_ST_DONE;
            MULT_ST_DONE: state_d = MULT_ST_IDLE;
            default:      state_d = MULT_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state_q)
            MULT_ST_LOAD, MULT_ST_ITER, MULT_ST_FIX: BUSY = 1'b1;
            MULT_ST_DONE:                            DONE = 1'b1;
            default: ;
        endcase
    end

    // Sign-corrected 64-bit product from the unsigned accumulator
    assign product = neg_q ? twoscomp64({acc_hi_q, mplier_q}) : {acc_hi_q, mplier_q};

    // Datapath next-state: capture, magnitude load, iterate, publish result
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        neg_d    = neg_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            MULT_ST_IDLE: begin
                if (START) begin
                    a_d      = A;
                    b_d      = B;
                    signed_d = SIGNED;
                end
            end
            MULT_ST_LOAD: begin
                mcand_d  = (signed_q && a_q[DATA_WIDTH-1]) ? twoscomp32(a_q) : a_q;
                mplier_d = (signed_q && b_q[DATA_WIDTH-1]) ? twoscomp32(b_q) : b_q;
                neg_d    = signed_q & (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
                acc_hi_d = '0;
                count_d  = '0;
            end
            MULT_ST_ITER: begin
                acc_hi_d = step_acc_hi;
                mplier_d = step_mplier;
                count_d  = count_q + 1'b1;
            end
            MULT_ST_FIX: begin
                hi_d = product[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_d = product[DATA_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            neg_q    <= neg_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: a cycle-level behavioural model tracks
// acceptance, latency and result; a compare process checks every cycle.
module tb_mult32_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mult32_seq dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIGNED (SIGNED),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product straight from integer arithmetic
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'({{32{a[31]}}, a});
            sb = longint'({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Model: phase = cycles since the accepting edge (-1 when idle).
    // Phases 0..33 are busy, phase 34 is the DONE cycle, results appear at phase 34.
    int          m_phase = -1;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_hilo  = '0;
    bit          chk_en  = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_phase <= -1;
            m_pend  <= '0;
            m_hilo  <= '0;
        end else if (m_phase < 0) begin
            if (START) begin
                m_phase <= 0;
                m_pend  <= ref_mul(A, B, SIGNED);
            end
        end else if (m_phase == 34) begin
            m_phase <= -1;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == 33) m_hilo <= m_pend;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 64'(BUSY), 64'(m_phase >= 0 && m_phase <= 33));
            check("done", 64'(DONE), 64'(m_phase == 34));
            check("hilo", {HI, LO}, m_hilo);
        end
    end

    // Issue one operation from IDLE; optionally pulse a rogue START at cycle noise_k
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int noise_k, output logic [63:0] res, output int lat);
        @(negedge CLK);
        START  = 1'b1;
        A      = a;
        B      = b;
        SIGNED = s;
        @(negedge CLK);
        START  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        SIGNED = 1'($urandom_range(0, 1));
        lat    = 1;
        while (!DONE && lat < 60) begin
            if (noise_k != 0 && lat == noise_k) begin
                START = 1'b1;
                A     = $urandom;
                B     = $urandom;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        START = 1'b0;
        if (lat >= 60) check("done_timeout", 64'(lat), 64'd35);
        res = {HI, LO};
        $display("op a=%h b=%h signed=%0d -> hi=%h lo=%h after %0d edges",
                 a, b, s, res[63:32], res[31:0], lat - 1);
    endtask

    logic [63:0] res;
    int          lat;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Pin the reference model to hand-computed products
        check("model_3x5",   ref_mul(32'd3, 32'd5, 1'b0), 64'h0000_0000_0000_000F);
        check("model_ffxff", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        check("model_m3x5",  ref_mul(32'hFFFF_FFFD, 32'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_minxmin", ref_mul(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

        // Directed cases
        run_op(32'd3, 32'd5, 1'b0, 0, res, lat);
        check("u3x5", res, 64'h0000_0000_0000_000F);
        check("latency", 64'(lat - 1), 64'd34);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, res, lat);
        check("uffxff", res, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, res, lat);
        check("sm3x5", res, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, res, lat);
        check("sm1xm1", res, 64'h0000_0000_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, res, lat);
        check("sminxmin", res, 64'h4000_0000_0000_0000);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0, res, lat);
        check("sminx1", res, 64'hFFFF_FFFF_8000_0000);
        run_op(32'd0, 32'h1234_5678, 1'b0, 0, res, lat);
        check("zero_latency", 64'(lat - 1), 64'd34);

        // Rogue START mid-ITER is ignored; result stays put afterwards
        run_op(32'd1234, 32'd5678, 1'b0, 10, res, lat);
        check("noise_result", res, 64'h0000_0000_006A_E9BC);
        check("noise_latency", 64'(lat - 1), 64'd34);
        repeat (10) @(negedge CLK);
        check("noise_hold", {HI, LO}, 64'h0000_0000_006A_E9BC);

        // Randomized operations, some with rogue STARTs
        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = 32'h8000_0000;
            run_op(ra, rb, rs, (i % 3 == 0) ? int'($urandom_range(2, 34)) : 0, res, lat);
            check("rand_result", res, ref_mul(ra, rb, rs));
        end

        // START held high across DONE: only re-acted on from IDLE
        @(negedge CLK);
        START  = 1'b1;
        A      = 32'hDEAD_BEEF;
        B      = 32'h0000_1001;
        SIGNED = 1'b1;
        repeat (80) @(negedge CLK);
        START = 1'b0;
        while (m_phase >= 0) @(negedge CLK);
        check("held_result", {HI, LO}, ref_mul(32'hDEAD_BEEF, 32'h0000_1001, 1'b1));

        // Asynchronous reset in the middle of ITER (count around 10)
        @(negedge CLK);
        START = 1'b1;
        A     = 32'hFFFF_0000;
        B     = 32'h0001_FFFF;
        SIGNED = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (11) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("arst_busy", 64'(BUSY), 64'd0);
        check("arst_done", 64'(DONE), 64'd0);
        check("arst_hilo", {HI, LO}, 64'd0);
        $display("async reset mid-ITER: busy=%0d done=%0d hi=%h lo=%h", BUSY, DONE, HI, LO);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run_op(32'd7, 32'd6, 1'b0, 0, res, lat);
        check("post_rst_7x6", res, 64'd42);
        check("post_rst_latency", 64'(lat - 1), 64'd34);

        repeat (3) @(negedge CLK);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
